// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: debounces two active-low buttons, holds a saturating
// target duty and ramps the live duty toward it only at PWM period boundaries.
module pwm_duty_ctrl #(
  parameter int PERIOD   = 50,
  parameter int STEP     = 5,
  parameter int RAMP     = 1,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_n,
  input  logic       dec_n,
  input  logic       period_end,
  output logic [7:0] duty,
  output logic [7:0] target,
  output logic       busy,
  output logic       at_max,
  output logic       at_min
);

  localparam int            CW      = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [8:0]    STEP9   = 9'(STEP);
  localparam logic [8:0]    RAMP9   = 9'(RAMP);
  localparam logic [7:0]    RAMP8   = 8'(RAMP);
  localparam logic [7:0]    PER8    = 8'(PERIOD);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]    btn_raw;
  logic [1:0]    meta;
  logic [1:0]    sync;
  db_state_t     st  [2];
  logic [CW-1:0] cnt [2];
  logic [1:0]    press;

  function automatic logic [7:0] sat_inc(input logic [7:0] t);
    logic [8:0] s;
    s = {1'b0, t} + STEP9;
    return (s > {1'b0, PER8}) ? PER8 : s[7:0];
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] t);
    return ({1'b0, t} < STEP9) ? 8'd0 : t - STEP9[7:0];
  endfunction

  function automatic logic [7:0] ramp_up(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] s;
    s = {1'b0, d} + RAMP9;
    return (s > {1'b0, t}) ? t : s[7:0];
  endfunction

  // Caller guarantees d > t, so the difference cannot underflow.
  function automatic logic [7:0] ramp_dn(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] diff;
    diff = {1'b0, d} - {1'b0, t};
    return (diff > RAMP9) ? d - RAMP8 : t;
  endfunction

  assign btn_raw = {dec_n, inc_n};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 2'b11;
      sync <= 2'b11;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (st[i])
          IDLE: begin
            if (!sync[i]) begin
              st[i]  <= PRESS_WAIT;
              cnt[i] <= CW'(1);
            end
          end
          PRESS_WAIT: begin
            if (sync[i]) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
              st[i]  <= HELD;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          HELD: begin
            if (sync[i]) begin
              st[i]  <= RELEASE_WAIT;
              cnt[i] <= CW'(1);
            end
          end
          RELEASE_WAIT: begin
            if (!sync[i]) begin
              st[i]  <= HELD;
              cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  // Press is decoded from the accepting transition so target moves on that same edge.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = (st[i] == PRESS_WAIT) && !sync[i] && (cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target <= '0;
    end else begin
      case (press)
        2'b01:   target <= sat_inc(target);
        2'b10:   target <= sat_dec(target);
        default: target <= target;
      endcase
    end
  end

  // Uses the pre-press target, so a simultaneous press lands at the next boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty <= '0;
    end else if (period_end) begin
      if (duty < target)      duty <= ramp_up(duty, target);
      else if (duty > target) duty <= ramp_dn(duty, target);
    end
  end

  assign busy   = (duty != target);
  assign at_max = (target == PER8);
  assign at_min = (target == 8'd0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with default parameters.
module tb_pwm_duty_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_n;
  logic       dec_n;
  logic       period_end;
  logic [7:0] duty;
  logic [7:0] target;
  logic       busy;
  logic       at_max;
  logic       at_min;

  int errors = 0;
  int checks = 0;

  pwm_duty_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .inc_n      (inc_n),
    .dec_n      (dec_n),
    .period_end (period_end),
    .duty       (duty),
    .target     (target),
    .busy       (busy),
    .at_max     (at_max),
    .at_min     (at_min)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; inc_n = 1'b1; dec_n = 1'b1; period_end = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic press_btn(input bit is_dec);
    if (is_dec) dec_n = 1'b0; else inc_n = 1'b0;
    tick(20);
    inc_n = 1'b1; dec_n = 1'b1;
    tick(20);
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick(1);
    period_end = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0; inc_n = 1'b1; dec_n = 1'b1; period_end = 1'b0;
    #3;
    checks++; if (duty !== 8'd0)   begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    checks++; if (target !== 8'd0) begin errors++; $display("FAIL reset_target: got %0d expected 0", target); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL reset_at_min: got %b expected 1", at_min); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max: got %b expected 0", at_max); end
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_hold();
    do_reset();
    inc_n = 1'b0;
    tick(17);
    checks++; if (target !== 8'd0) begin errors++; $display("FAIL hold_edge17: got %0d expected 0", target); end
    tick(1);
    checks++; if (target !== 8'd5) begin errors++; $display("FAIL hold_edge18: got %0d expected 5", target); end
    checks++; if (duty !== 8'd0)   begin errors++; $display("FAIL hold_duty: got %0d expected 0", duty); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
    tick(12);
    checks++; if (target !== 8'd5) begin errors++; $display("FAIL hold_norepeat: got %0d expected 5", target); end
    inc_n = 1'b1;
    tick(20);
  endtask

  task automatic test_bounce();
    do_reset();
    inc_n = 1'b0; tick(10);
    inc_n = 1'b1; tick(1);
    inc_n = 1'b0; tick(17);
    checks++; if (target !== 8'd0) begin errors++; $display("FAIL bounce_early: got %0d expected 0", target); end
    tick(1);
    checks++; if (target !== 8'd5) begin errors++; $display("FAIL bounce_accept: got %0d expected 5", target); end
    tick(2);
    checks++; if (target !== 8'd5) begin errors++; $display("FAIL bounce_single: got %0d expected 5", target); end
    inc_n = 1'b1;
    tick(20);
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (10) press_btn(1'b0);
    checks++; if (target !== 8'd50) begin errors++; $display("FAIL sat_ten_inc: got %0d expected 50", target); end
    repeat (2) press_btn(1'b0);
    checks++; if (target !== 8'd50) begin errors++; $display("FAIL sat_clamp_hi: got %0d expected 50", target); end
    checks++; if (at_max !== 1'b1)  begin errors++; $display("FAIL sat_at_max: got %b expected 1", at_max); end
    press_btn(1'b1);
    checks++; if (target !== 8'd45) begin errors++; $display("FAIL sat_first_dec: got %0d expected 45", target); end
    checks++; if (at_max !== 1'b0)  begin errors++; $display("FAIL sat_at_max_clear: got %b expected 0", at_max); end
    repeat (11) press_btn(1'b1);
    checks++; if (target !== 8'd0)  begin errors++; $display("FAIL sat_clamp_lo: got %0d expected 0", target); end
    checks++; if (at_min !== 1'b1)  begin errors++; $display("FAIL sat_at_min: got %b expected 1", at_min); end
  endtask

  task automatic test_ramp();
    do_reset();
    repeat (2) press_btn(1'b0);
    checks++; if (target !== 8'd10) begin errors++; $display("FAIL ramp_target: got %0d expected 10", target); end
    for (int k = 1; k <= 10; k++) begin
      tick(48);
      checks++; if (duty !== 8'(k - 1)) begin errors++; $display("FAIL ramp_hold_%0d: got %0d expected %0d", k, duty, k - 1); end
      period_end = 1'b1;
      tick(1);
      period_end = 1'b0;
      checks++; if (duty !== 8'(k)) begin errors++; $display("FAIL ramp_step_%0d: got %0d expected %0d", k, duty, k); end
      checks++; if (busy !== (k < 10)) begin errors++; $display("FAIL ramp_busy_%0d: got %b expected %b", k, busy, (k < 10)); end
    end
    pulse_pe();
    checks++; if (duty !== 8'd10) begin errors++; $display("FAIL ramp_settled: got %0d expected 10", duty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) press_btn(1'b0);
    inc_n = 1'b0; dec_n = 1'b0;
    tick(20);
    checks++; if (target !== 8'd10) begin errors++; $display("FAIL simul_both: got %0d expected 10", target); end
    inc_n = 1'b1; dec_n = 1'b1;
    tick(20);
    repeat (10) pulse_pe();
    checks++; if (duty !== 8'd10) begin errors++; $display("FAIL simul_preramp: got %0d expected 10", duty); end
    inc_n = 1'b0;
    tick(17);
    period_end = 1'b1;
    tick(1);
    period_end = 1'b0;
    checks++; if (target !== 8'd15) begin errors++; $display("FAIL simul_pe_target: got %0d expected 15", target); end
    checks++; if (duty !== 8'd10)   begin errors++; $display("FAIL simul_pe_oldtarget: got %0d expected 10", duty); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL simul_pe_busy: got %b expected 1", busy); end
    inc_n = 1'b1;
    pulse_pe();
    checks++; if (duty !== 8'd11)   begin errors++; $display("FAIL simul_next_pe: got %0d expected 11", duty); end
    tick(20);
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) press_btn(1'b0);
    repeat (4) pulse_pe();
    checks++; if (duty !== 8'd4 || target !== 8'd20) begin errors++; $display("FAIL mid_setup: got duty %0d target %0d expected 4 20", duty, target); end
    inc_n = 1'b0;
    tick(10);
    #2 reset = 1'b0;
    #1;
    checks++; if (duty !== 8'd0)   begin errors++; $display("FAIL mid_async_duty: got %0d expected 0", duty); end
    checks++; if (target !== 8'd0) begin errors++; $display("FAIL mid_async_target: got %0d expected 0", target); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
    checks++; if (at_min !== 1'b1 || at_max !== 1'b0) begin errors++; $display("FAIL mid_async_flags: got min %b max %b expected 1 0", at_min, at_max); end
    tick(2);
    reset = 1'b1;
    tick(17);
    checks++; if (target !== 8'd0) begin errors++; $display("FAIL mid_redebounce_early: got %0d expected 0", target); end
    tick(1);
    checks++; if (target !== 8'd5) begin errors++; $display("FAIL mid_redebounce_accept: got %0d expected 5", target); end
    inc_n = 1'b1;
    tick(20);
  endtask

  initial begin
    test_reset();
    test_hold();
    test_bounce();
    test_saturation();
    test_ramp();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
